// File: rtl/cp0_reg.sv
// cp0_reg: coprocessor-0 register file, written at writeback.
//   clk, rst              clock; synchronous active-high reset
//   we_i/waddr_i/data_i   CP0 write port (from the MEM/WB latch)
//   raddr_i / data_o      combinational read port for mfc0 in EX
//   int_i                 external interrupt lines, sampled into Cause.IP[7:2]
//   excepttype_i, current_inst_addr_i, is_in_delayslot_i
//                         exception record from the MEM-stage exception unit
//   count_o .. prid_o     architectural register values
//   timer_int_o           sticky Count==Compare interrupt, cleared by a Compare write
module cp0_reg #(
    parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
    parameter logic [31:0] STATUS_RST   = 32'h10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    typedef enum logic [4:0] {
        REG_COUNT   = 5'd9,
        REG_COMPARE = 5'd11,
        REG_STATUS  = 5'd12,
        REG_CAUSE   = 5'd13,
        REG_EPC     = 5'd14,
        REG_PRID    = 5'd15,
        REG_CONFIG  = 5'd16
    } cp0_addr_e;

    // Software-writable Cause bits: IV, WP, IP1, IP0
    localparam logic [31:0] CAUSE_WMASK = 32'h00C00300;

    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] status_q,  status_d;
    logic [31:0] cause_q,   cause_d;
    logic [31:0] epc_q,     epc_d;
    logic        timer_q,   timer_d;

    logic        exc_handled;
    logic [4:0]  exc_code;

    always_comb begin
        exc_handled = 1'b1;
        exc_code    = 5'd0;
        case (excepttype_i)
            32'h0000_0001: exc_code = 5'd0;
            32'h0000_0008: exc_code = 5'd8;
            32'h0000_000a: exc_code = 5'd10;
            32'h0000_000c: exc_code = 5'd12;
            32'h0000_000d: exc_code = 5'd13;
            default:       exc_handled = 1'b0;
        endcase
    end

    // Layered next-state: auto-update, then software write, then exception.
    // Later layers override only the fields they touch.
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        status_d  = status_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        timer_d   = timer_q;

        cause_d[15:10] = int_i;
        if (compare_q != '0 && count_q == compare_q) begin
            timer_d = 1'b1;
        end

        if (we_i) begin
            case (waddr_i)
                REG_COUNT:   count_d = data_i;
                REG_COMPARE: begin
                    compare_d = data_i;
                    timer_d   = 1'b0;
                end
                REG_STATUS:  status_d = data_i;
                REG_CAUSE:   cause_d = (cause_d & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
                REG_EPC:     epc_d = data_i;
                default: ;
            endcase
        end

        if (exc_handled) begin
            // Nested exception (EXL already set) keeps the original return address.
            if (!status_q[1]) begin
                epc_d       = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                                : current_inst_addr_i;
                cause_d[31] = is_in_delayslot_i;
            end
            status_d[1]   = 1'b1;
            cause_d[6:2]  = exc_code;
        end else if (excepttype_i == 32'h0000_000e) begin
            status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            status_q  <= STATUS_RST;
            cause_q   <= '0;
            epc_q     <= '0;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        data_o = '0;
        case (raddr_i)
            REG_COUNT:   data_o = count_q;
            REG_COMPARE: data_o = compare_q;
            REG_STATUS:  data_o = status_q;
            REG_CAUSE:   data_o = cause_q;
            REG_EPC:     data_o = epc_q;
            REG_PRID:    data_o = PRID_VALUE;
            REG_CONFIG:  data_o = CONFIG_VALUE;
            default:     data_o = '0;
        endcase
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign config_o    = CONFIG_VALUE;
    assign prid_o      = PRID_VALUE;
    assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed and randomized checks of cp0_reg against a
// behavioural model of the CP0 register rules.
module tb_cp0_reg;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    cp0_reg #(
        .PRID_VALUE   (32'h004C0102),
        .CONFIG_VALUE (32'h00008000),
        .STATUS_RST   (32'h10000000)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .data_i              (data_i),
        .raddr_i             (raddr_i),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .data_o              (data_o),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .config_o            (config_o),
        .prid_o              (prid_o),
        .timer_int_o         (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
    logic        m_timer;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h004C0102;
            5'd16:   return 32'h00008000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_all();
        check("count",   count_o,   m_count);
        check("compare", compare_o, m_compare);
        check("status",  status_o,  m_status);
        check("cause",   cause_o,   m_cause);
        check("epc",     epc_o,     m_epc);
        check("timer",   {31'b0, timer_int_o}, {31'b0, m_timer});
        check("prid",    prid_o,    32'h004C0102);
        check("config",  config_o,  32'h00008000);
        check("data_o",  data_o,    model_read(raddr_i));
    endtask

    // One clock: compute the model's next state from the inputs, take the
    // edge, then compare every output and return inputs to idle.
    task automatic tick();
        logic [31:0] n_count, n_compare, n_status, n_cause, n_epc;
        logic        n_timer;
        logic        handled;
        int          code;
        if (rst) begin
            n_count = 0; n_compare = 0; n_status = 32'h10000000;
            n_cause = 0; n_epc = 0; n_timer = 1'b0;
        end else begin
            n_count   = m_count + 1;
            n_compare = m_compare;
            n_status  = m_status;
            n_epc     = m_epc;
            n_cause   = (m_cause & 32'hFFFF03FF) | (32'(int_i) << 10);
            n_timer   = m_timer || (m_compare != 0 && m_count == m_compare);
            if (we_i) begin
                if (waddr_i == 9)  n_count = data_i;
                if (waddr_i == 11) begin n_compare = data_i; n_timer = 1'b0; end
                if (waddr_i == 12) n_status = data_i;
                if (waddr_i == 13) n_cause = (n_cause & 32'hFF3FFCFF) | (data_i & 32'h00C00300);
                if (waddr_i == 14) n_epc = data_i;
            end
            handled = 1'b1;
            code    = 0;
            case (excepttype_i)
                32'h1:   code = 0;
                32'h8:   code = 8;
                32'ha:   code = 10;
                32'hc:   code = 12;
                32'hd:   code = 13;
                default: handled = 1'b0;
            endcase
            if (handled) begin
                if (m_status[1] == 1'b0) begin
                    n_epc = is_in_delayslot_i ? current_inst_addr_i - 4 : current_inst_addr_i;
                    n_cause[31] = is_in_delayslot_i;
                end
                n_status[1]  = 1'b1;
                n_cause[6:2] = code[4:0];
            end else if (excepttype_i == 32'he) begin
                n_status[1] = 1'b0;
            end
        end
        @(posedge clk);
        m_count = n_count; m_compare = n_compare; m_status = n_status;
        m_cause = n_cause; m_epc = n_epc; m_timer = n_timer;
        #1;
        check_all();
        rst = 1'b0; we_i = 1'b0; excepttype_i = 0; is_in_delayslot_i = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; data_i = d;
        tick();
    endtask

    task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds);
        excepttype_i = t; current_inst_addr_i = pc; is_in_delayslot_i = ds;
        tick();
    endtask

    initial begin
        rst = 1'b1; we_i = 1'b0; waddr_i = 0; data_i = 0; raddr_i = 5'd12;
        int_i = 0; excepttype_i = 0; current_inst_addr_i = 0; is_in_delayslot_i = 0;
        m_count = 'x; m_compare = 'x; m_status = 'x; m_cause = 'x; m_epc = 'x; m_timer = 'x;

        // Reset values, then free-running count
        tick();
        check("rst_status", status_o, 32'h10000000);
        check("rst_count",  count_o,  32'h0);
        check("rst_timer",  {31'b0, timer_int_o}, 32'h0);
        for (int unsigned i = 0; i < 5; i++) tick();
        check("count5", count_o, 32'd5);

        // Timer: sticky until Compare is rewritten
        raddr_i = 5'd11;
        wr(5'd11, 32'h20);
        wr(5'd9, 32'h1E);
        tick(); tick(); tick();
        check("timer_set", {31'b0, timer_int_o}, 32'h1);
        for (int unsigned i = 0; i < 4; i++) tick();
        check("timer_sticky", {31'b0, timer_int_o}, 32'h1);
        wr(5'd11, 32'h1000);
        check("timer_clr", {31'b0, timer_int_o}, 32'h0);

        // Syscall in delay slot, then nested RI, then eret
        raddr_i = 5'd14;
        exc(32'h8, 32'h100, 1'b1);
        check("sys_epc",  epc_o, 32'hFC);
        check("sys_bd",   {31'b0, cause_o[31]}, 32'h1);
        check("sys_code", {27'b0, cause_o[6:2]}, 32'd8);
        check("sys_exl",  {31'b0, status_o[1]}, 32'h1);
        exc(32'ha, 32'h200, 1'b0);
        check("nest_epc",  epc_o, 32'hFC);
        check("nest_code", {27'b0, cause_o[6:2]}, 32'd10);
        exc(32'he, 32'h0, 1'b0);
        check("eret_exl", {31'b0, status_o[1]}, 32'h0);

        // Write vs exception in same cycle; Cause write mask
        raddr_i = 5'd12;
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0;
        exc(32'h1, 32'h300, 1'b0);
        check("wr_exc_status", status_o, 32'h00000002);
        rst = 1'b1; tick();
        int_i = 6'h15; raddr_i = 5'd13;
        wr(5'd13, 32'hFFFFFFFF);
        check("cause_mask", cause_o, 32'h00C05700);

        // Count wrap and mid-run reset
        wr(5'd9, 32'hFFFFFFFF);
        tick();
        check("count_wrap", count_o, 32'h0);
        wr(5'd14, 32'h12345678);
        rst = 1'b1; tick();
        check("mid_rst_epc",   epc_o,   32'h0);
        check("mid_rst_cause", cause_o, 32'h0);

        // Randomized traffic
        for (int unsigned i = 0; i < 400; i++) begin
            int unsigned sel;
            logic [4:0] addrs [8];
            addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
            int_i   = 6'($urandom);
            raddr_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 7)];
            we_i    = ($urandom_range(0, 2) == 0);
            waddr_i = addrs[$urandom_range(0, 7)];
            data_i  = $urandom;
            if (waddr_i == 5'd11 || waddr_i == 5'd9) data_i = 32'($urandom_range(0, 40));
            sel = $urandom_range(0, 11);
            case (sel)
                0: excepttype_i = 32'h1;
                1: excepttype_i = 32'h8;
                2: excepttype_i = 32'ha;
                3: excepttype_i = 32'hc;
                4: excepttype_i = 32'hd;
                5: excepttype_i = 32'he;
                6: excepttype_i = 32'h5;
                7: excepttype_i = $urandom;
                default: excepttype_i = 32'h0;
            endcase
            current_inst_addr_i = $urandom;
            is_in_delayslot_i   = 1'($urandom);
            rst = ($urandom_range(0, 79) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
